irt_tracker: RTL and testbench

Clocked, parametrised instruction register table for the ESM scheduler. Each buffer slot holds one-hot source and destination register masks for one in-flight instruction. Slots are allocated in program order into a circular buffer, then issued and completed out of order, and retired in order. Every cycle the block publishes a per-slot ready vector, clear of RAW, WAR and WAW hazards against older in-flight slots, for the issue selector.

---
 rtl/esm_pkg.sv | 34 +++
 rtl/irt_tracker_if.sv | 40 ++++
 rtl/irt_hazard_row.sv | 38 +++
 rtl/irt_tracker.sv | 118 +++++++++++
 tb/tb_irt_tracker.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/esm_pkg.sv
// Shared types and helpers for the ESM scheduler instruction register table.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package esm_pkg;

    localparam int IRT_REGNUM = 32;
    localparam int IRT_BS     = 16;
    localparam int IRT_RW     = $clog2(IRT_REGNUM);

    // Masks are sized for the largest supported register file; narrower
    // configurations leave the upper bits at zero.
    typedef struct packed {
        logic [IRT_REGNUM-1:0] rs;
        logic [IRT_REGNUM-1:0] rd;
        logic                  valid;
        logic                  issued;
        logic                  done;
    } irt_slot_t;

    // Register index to one-hot mask; register 0 drops out when it is hardwired.
    function automatic logic [IRT_REGNUM-1:0] onehot_mask(
        input logic [IRT_RW-1:0] idx,
        input logic              zero_reg
    );
        logic [IRT_REGNUM-1:0] m;
        m = '0;
        m[idx] = 1'b1;
        if (zero_reg) begin
            m[0] = 1'b0;
        end
        return m;
    endfunction

endpackage

// File: rtl/irt_tracker_if.sv
// Scheduler-side bundle for the instruction register table.
// Latency: wires only.
// Backpressure: alloc_ready gates allocation; issue/complete are fire-and-forget.
interface irt_tracker_if
    import esm_pkg::*;
#(
    parameter int REGNUM = IRT_REGNUM,
    parameter int BS     = IRT_BS
) ();
    localparam int RW = $clog2(REGNUM);
    localparam int IW = $clog2(BS);

    logic          alloc_valid;
    logic          alloc_ready;
    logic [RW-1:0] alloc_rs1;
    logic [RW-1:0] alloc_rs2;
    logic [RW-1:0] alloc_rd;
    logic [IW-1:0] alloc_index;
    logic          issue_valid;
    logic [IW-1:0] issue_index;
    logic          complete_valid;
    logic [IW-1:0] complete_index;
    logic [BS-1:0] ready_vec;
    logic          full;
    logic          empty;
    logic [IW:0]   count;

    modport master (
        output alloc_valid, alloc_rs1, alloc_rs2, alloc_rd,
        output issue_valid, issue_index, complete_valid, complete_index,
        input  alloc_ready, alloc_index, ready_vec, full, empty, count
    );

    modport slave (
        input  alloc_valid, alloc_rs1, alloc_rs2, alloc_rd,
        input  issue_valid, issue_index, complete_valid, complete_index,
        output alloc_ready, alloc_index, ready_vec, full, empty, count
    );

endinterface

// File: rtl/irt_hazard_row.sv
// RAW/WAR/WAW hazard check of one slot against every older live slot.
// Latency: purely combinational.
// Backpressure: none.
module irt_hazard_row #(
    parameter int REGNUM = 32,
    parameter int BS     = 16,
    parameter int I      = 0
) (
    input  logic [$clog2(BS)-1:0]    head,
    input  logic [BS-1:0]            live,
    input  logic [BS-1:0][REGNUM-1:0] rs_all,
    input  logic [BS-1:0][REGNUM-1:0] rd_all,
    output logic                     hazard
);
    localparam int IW = $clog2(BS);
    localparam logic [IW-1:0] SLOT = IW'(I);

    logic [IW-1:0] age_i;
    logic [IW-1:0] age_j;

    // Age is distance from head; any live older slot sharing a register blocks issue.
    always_comb begin
        hazard = 1'b0;
        age_i  = SLOT - head;
        age_j  = '0;
        for (int j = 0; j < BS; j++) begin
            age_j = IW'(j) - head;
            if (j != I && live[j] && (age_j < age_i)) begin
                if (|(rd_all[j] & rs_all[I]) ||
                    |(rd_all[j] & rd_all[I]) ||
                    |(rs_all[j] & rd_all[I])) begin
                    hazard = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/irt_tracker.sv
// Circular instruction register table publishing per-slot hazard-free ready bits.
// Latency: ready_vec reflects an allocate/complete one cycle after its edge.
// Backpressure: alloc_ready low while full, even when a retire happens that cycle.
module irt_tracker
    import esm_pkg::*;
#(
    parameter int REGNUM   = IRT_REGNUM,
    parameter int BS       = IRT_BS,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    irt_tracker_if.slave bus
);
    localparam int IW = $clog2(BS);
    localparam logic [IW:0] CAP = BS[IW:0];

    irt_slot_t                slot_q [BS];
    logic [IW-1:0]            head_q;
    logic [IW-1:0]            tail_q;
    logic [IW:0]              count_q;

    logic                     full;
    logic                     alloc_fire;
    logic                     issue_fire;
    logic                     complete_fire;
    logic                     retire;
    logic [BS-1:0]            live;
    logic [BS-1:0]            hazard;
    logic [BS-1:0]            ready;
    logic [BS-1:0][REGNUM-1:0] rs_all;
    logic [BS-1:0][REGNUM-1:0] rd_all;
    logic [IRT_REGNUM-1:0]    new_rs;
    logic [IRT_REGNUM-1:0]    new_rd;

    // Flatten slot state for the hazard rows and form the ready vector.
    always_comb begin
        live   = '0;
        ready  = '0;
        rs_all = '0;
        rd_all = '0;
        for (int i = 0; i < BS; i++) begin
            live[i]   = slot_q[i].valid && !slot_q[i].done;
            rs_all[i] = slot_q[i].rs[REGNUM-1:0];
            rd_all[i] = slot_q[i].rd[REGNUM-1:0];
            ready[i]  = slot_q[i].valid && !slot_q[i].issued && !hazard[i];
        end
    end

    for (genvar g = 0; g < BS; g++) begin : g_row
        irt_hazard_row #(
            .REGNUM (REGNUM),
            .BS     (BS),
            .I      (g)
        ) u_row (
            .head   (head_q),
            .live   (live),
            .rs_all (rs_all),
            .rd_all (rd_all),
            .hazard (hazard[g])
        );
    end

    // Event qualification; all decisions use registered state only.
    always_comb begin
        full          = (count_q == CAP);
        alloc_fire    = bus.alloc_valid && !full;
        issue_fire    = bus.issue_valid && ready[bus.issue_index];
        complete_fire = bus.complete_valid
                        && slot_q[bus.complete_index].valid
                        && slot_q[bus.complete_index].issued
                        && !slot_q[bus.complete_index].done;
        retire        = slot_q[head_q].valid && slot_q[head_q].done;
        new_rs        = onehot_mask(IRT_RW'(bus.alloc_rs1), ZERO_REG)
                      | onehot_mask(IRT_RW'(bus.alloc_rs2), ZERO_REG);
        new_rd        = onehot_mask(IRT_RW'(bus.alloc_rd), ZERO_REG);
    end

    // Slot, pointer and occupancy update; the four events touch disjoint slots.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BS; i++) begin
                slot_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (alloc_fire) begin
                slot_q[tail_q] <= '{rs: new_rs, rd: new_rd, valid: 1'b1,
                                    issued: 1'b0, done: 1'b0};
                tail_q         <= tail_q + IW'(1);
            end
            if (issue_fire) begin
                slot_q[bus.issue_index].issued <= 1'b1;
            end
            if (complete_fire) begin
                slot_q[bus.complete_index].done <= 1'b1;
            end
            if (retire) begin
                slot_q[head_q].valid <= 1'b0;
                head_q               <= head_q + IW'(1);
            end
            count_q <= count_q + (IW+1)'(alloc_fire) - (IW+1)'(retire);
        end
    end

    // Status outputs, all from registers.
    always_comb begin
        bus.alloc_ready = !full;
        bus.alloc_index = tail_q;
        bus.ready_vec   = ready;
        bus.full        = full;
        bus.empty       = (count_q == '0);
        bus.count       = count_q;
    end

endmodule

// File: tb/tb_irt_tracker.sv
// Directed self-checking bench for irt_tracker.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: exercises refused allocation while full.
module tb_irt_tracker;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   compared = 0;
    int   mismatched = 0;

    always #5 clk = ~clk;

    irt_tracker_if #(.REGNUM(32), .BS(16)) bus ();

    irt_tracker #(.REGNUM(32), .BS(16), .ZERO_REG(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        bus.alloc_valid    = 1'b0;
        bus.issue_valid    = 1'b0;
        bus.complete_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic alloc(input int rs1, input int rs2, input int rd);
        bus.alloc_valid = 1'b1;
        bus.alloc_rs1   = 5'(rs1);
        bus.alloc_rs2   = 5'(rs2);
        bus.alloc_rd    = 5'(rd);
        tick();
    endtask

    task automatic issue(input int idx);
        bus.issue_valid = 1'b1;
        bus.issue_index = 4'(idx);
        tick();
    endtask

    task automatic complete(input int idx);
        bus.complete_valid = 1'b1;
        bus.complete_index = 4'(idx);
        tick();
    endtask

    initial begin
        bus.alloc_valid = 0; bus.alloc_rs1 = 0; bus.alloc_rs2 = 0; bus.alloc_rd = 0;
        bus.issue_valid = 0; bus.issue_index = 0;
        bus.complete_valid = 0; bus.complete_index = 0;
        tick();
        do_reset();

        // Reset state and first allocation
        chk("rst_ready", 32'(bus.ready_vec), 32'h0);
        chk("rst_empty", 32'(bus.empty), 32'h1);
        chk("rst_full", 32'(bus.full), 32'h0);
        chk("rst_count", 32'(bus.count), 32'h0);
        chk("rst_aidx", 32'(bus.alloc_index), 32'h0);
        chk("rst_ardy", 32'(bus.alloc_ready), 32'h1);
        alloc(1, 2, 3);
        chk("a1_ready", 32'(bus.ready_vec), 32'h0001);
        chk("a1_count", 32'(bus.count), 32'h1);
        chk("a1_aidx", 32'(bus.alloc_index), 32'h1);
        chk("a1_empty", 32'(bus.empty), 32'h0);

        // RAW; issue of a blocked slot is ignored
        do_reset();
        alloc(0, 0, 5);
        alloc(5, 0, 6);
        chk("raw_ready", 32'(bus.ready_vec), 32'h0001);
        issue(1);
        chk("raw_blk_iss", 32'(bus.ready_vec), 32'h0001);
        issue(0);
        chk("raw_iss0", 32'(bus.ready_vec), 32'h0000);
        complete(0);
        chk("raw_release", 32'(bus.ready_vec), 32'h0002);
        chk("raw_cnt_pre", 32'(bus.count), 32'h2);
        tick();
        chk("raw_retire", 32'(bus.count), 32'h1);
        chk("raw_aidx", 32'(bus.alloc_index), 32'h2);
        chk("raw_ready2", 32'(bus.ready_vec), 32'h0002);

        // WAR then WAW
        do_reset();
        alloc(7, 0, 8);
        alloc(0, 0, 7);
        alloc(0, 0, 7);
        chk("war_ready", 32'(bus.ready_vec), 32'h0001);
        issue(0);
        complete(0);
        chk("war_rel", 32'(bus.ready_vec), 32'h0002);
        issue(1);
        chk("waw_hold", 32'(bus.ready_vec), 32'h0000);
        complete(1);
        chk("waw_rel", 32'(bus.ready_vec), 32'h0004);

        // Register zero never hazards
        do_reset();
        alloc(0, 0, 0);
        alloc(0, 0, 0);
        chk("zero_ready", 32'(bus.ready_vec), 32'h0003);

        // Fill, refused allocation, wrap
        do_reset();
        for (int k = 0; k < 16; k++) alloc(0, 0, k + 1);
        chk("full_flag", 32'(bus.full), 32'h1);
        chk("full_ardy", 32'(bus.alloc_ready), 32'h0);
        chk("full_count", 32'(bus.count), 32'd16);
        chk("full_ready", 32'(bus.ready_vec), 32'hFFFF);
        alloc(0, 0, 20);
        chk("full_refuse", 32'(bus.count), 32'd16);
        chk("full_aidx", 32'(bus.alloc_index), 32'h0);
        issue(0);
        bus.alloc_valid = 1'b1;
        bus.alloc_rd    = 5'd20;
        complete(0);
        chk("full_cmp_cnt", 32'(bus.count), 32'd16);
        alloc(0, 0, 20);
        chk("full_ret_cnt", 32'(bus.count), 32'd15);
        chk("full_ret_aidx", 32'(bus.alloc_index), 32'h0);
        chk("full_ret_full", 32'(bus.full), 32'h0);
        alloc(0, 0, 20);
        chk("reuse_cnt", 32'(bus.count), 32'd16);
        chk("reuse_aidx", 32'(bus.alloc_index), 32'h1);
        chk("reuse_ready", 32'(bus.ready_vec), 32'hFFFF);
        for (int k = 1; k < 16; k++) issue(k);
        for (int k = 1; k < 16; k++) complete(k);
        chk("drain_cnt", 32'(bus.count), 32'd2);
        tick();
        chk("wrap_cnt", 32'(bus.count), 32'd1);
        chk("wrap_ready", 32'(bus.ready_vec), 32'h0001);
        alloc(0, 0, 20);
        chk("wrap_waw", 32'(bus.ready_vec), 32'h0001);

        // Reset mid-run with an allocate in the reset cycle
        do_reset();
        for (int k = 0; k < 5; k++) alloc(0, 0, k + 1);
        issue(0);
        issue(1);
        chk("mid_ready", 32'(bus.ready_vec), 32'h001C);
        rst = 1'b1;
        bus.alloc_valid = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_count", 32'(bus.count), 32'h0);
        chk("mid_ready0", 32'(bus.ready_vec), 32'h0);
        chk("mid_empty", 32'(bus.empty), 32'h1);
        chk("mid_aidx", 32'(bus.alloc_index), 32'h0);

        // Out-of-order completion, in-order retirement
        for (int k = 0; k < 5; k++) alloc(0, 0, k + 1);
        complete(3);
        issue(0);
        issue(1);
        issue(2);
        chk("ooo_ready", 32'(bus.ready_vec), 32'h0018);
        complete(2);
        tick();
        chk("ooo_hold", 32'(bus.count), 32'd5);
        complete(0);
        chk("ooo_c0", 32'(bus.count), 32'd5);
        complete(1);
        chk("ooo_r0", 32'(bus.count), 32'd4);
        tick();
        chk("ooo_r1", 32'(bus.count), 32'd3);
        tick();
        chk("ooo_r2", 32'(bus.count), 32'd2);
        tick();
        chk("ooo_nocmp", 32'(bus.count), 32'd2);
        bus.complete_valid = 1'b1;
        bus.complete_index = 4'd3;
        issue(3);
        tick();
        chk("iss_cmp_same", 32'(bus.count), 32'd2);
        complete(3);
        tick();
        chk("late_ret", 32'(bus.count), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
